pixie_fb_capture: RTL and testbench
===================================

// Module: pixie_fb_capture
// PURPOSE
//  Upstream of the 1861 video backend: captures DMA bytes (mem_wr_en/mem_data
//  from the Pixie frontend) into a double-buffered framebuffer and serves the
//  backend's fb_addr/fb_read_en/fb_data fetch port. Completed frames are
//  swapped in at frame boundary, so the display never shows a torn frame.
// PARAMETERS
//  FB_BYTES    256    bytes per complete frame (64x32 px, 8 bytes/row)
//  ADDR_W      10     width of read address fb_addr
//  BLANK_BYTE  8'h00  read data returned for fb_addr >= FB_BYTES
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high
//  clk_enable   in   1       CPU-rate enable; DMA-side inputs sampled only when 1
//  frame_start  in   1       frontend frame-boundary strobe (qualified by clk_enable)
//  dma_wr_en    in   1       DMA byte valid (qualified by clk_enable)
//  dma_data     in   8       DMA byte
//  fb_read_en   in   1       backend read request
//  fb_addr      in   ADDR_W  backend read address (display bank)
//  fb_data      out  8       read data, 1-cycle latency
//  bank_sel     out  1       bank currently displayed (0/1)
//  frame_swap   out  1       1-cycle pulse when banks swap
//  short_frame  out  1       sticky: a non-empty frame ended with < FB_BYTES bytes
//  overflow     out  1       sticky: > FB_BYTES bytes received in one frame
// BEHAVIOUR
//  Reset: fb_data=0, bank_sel=0, frame_swap=0, short_frame=0, overflow=0,
//   write pointer=0, state=EMPTY. RAM contents not cleared.
//  Write side (event = clk_enable & dma_wr_en): byte written to bank ~bank_sel
//   at wr_ptr; wr_ptr increments; at FB_BYTES-1 it wraps to 0 and state->FULL.
//  FSM (advances on clk_enable only): EMPTY -write-> FILLING; FILLING
//   -wr_ptr wraps-> FULL; FULL -write-> FULL, overflow<=1, byte overwrites
//   from addr 0. Any state -frame_start-> EMPTY, wr_ptr<=0.
//  Frame boundary (clk_enable & frame_start):
//   FULL    -> bank_sel toggles, frame_swap pulses next clk.
//   FILLING -> no swap, short_frame<=1, partial data discarded.
//   EMPTY   -> no swap, no flag (display off: last frame held).
//  frame_start and dma_wr_en same enable: frame_start evaluated first (swap
//   decision on old state), then byte written at addr 0 of the new write bank
//   (bank after toggle); wr_ptr=1, state=FILLING.
//  Read side: every clk (independent of clk_enable); if fb_read_en,
//   fb_data <= RAM[bank_sel][fb_addr] next clk, or BLANK_BYTE when
//   fb_addr >= FB_BYTES; if !fb_read_en, fb_data holds. Read of bank changed
//   by a swap in cycle N uses new bank from cycle N+1.
//  Write and read never target the same bank; no collision logic required.
//  Reset mid-frame: partial frame dropped, bank_sel=0 shown (stale RAM).
//  Sticky flags clear only on reset.
// STRUCTURE
//  Package pixie_pkg: FB_BYTES, FB_AW=$clog2(FB_BYTES), state enum
//   {EMPTY,FILLING,FULL}.
//  Sub-module pixie_fb_dpram: simple dual-port RAM, 2*FB_BYTES x 8, one write
//   port, one registered read port, address = {bank, offset}; infers BRAM.
//  Top holds FSM, wr_ptr, bank_sel, flags, blank-address mux.
// TESTING
//  1 Write 256 bytes 0x00..0xFF, pulse frame_start -> frame_swap once,
//    bank_sel=1; read addr 0x05 -> fb_data=0x05 one clk later; addr 0x120 -> 0x00.
//  2 Write 100 bytes then frame_start -> no swap, short_frame=1, bank_sel held,
//    reads still return frame 1 data.
//  3 No writes between two frame_starts -> no swap, no flags, display unchanged.
//  4 Write 257 bytes (257th=0xAA) -> overflow=1, write-bank addr 0 = 0xAA after
//    swap; state FULL so swap occurs at next frame_start.
//  5 frame_start and dma_wr_en(0x5A) same enable after full frame -> swap, new
//    write bank addr 0 = 0x5A visible after following full frame.
//  6 Assert reset after 50 bytes -> all outputs reset values; next 256 bytes +
//    frame_start -> swap to bank 1 with only post-reset data.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared constants and types for the Pixie framebuffer capture block.
package pixie_pkg;

  localparam int unsigned FB_BYTES = 256;
  localparam int unsigned FB_AW    = $clog2(FB_BYTES);
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } fb_state_e;

  // RAM address: bank select on top of the byte offset within a frame.
  typedef struct packed {
    logic             bank;
    logic [FB_AW-1:0] offset;
  } fb_ram_addr_t;

endpackage

// File: rtl/pixie_fb_dpram.sv
// Two-bank frame store: one write port, one registered read port.
module pixie_fb_dpram
  import pixie_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  fb_ram_addr_t      wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  fb_ram_addr_t      rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2*FB_BYTES];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array is left uncleared so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register with synchronous reset, holds when not reading.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pixie_fb_capture.sv
// Captures Pixie DMA bytes into a double-buffered framebuffer and serves the
// video backend's fetch port; completed frames swap in at frame boundaries.
module pixie_fb_capture
  import pixie_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 10,
  parameter logic [DATA_W-1:0] BLANK_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              frame_start,
  input  logic              dma_wr_en,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              fb_read_en,
  input  logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              bank_sel,
  output logic              frame_swap,
  output logic              short_frame,
  output logic              overflow
);

  fb_state_e         state_q;
  logic [FB_AW-1:0]  wr_ptr_q;
  logic              bank_sel_q;
  logic              swap_q;
  logic              short_q;
  logic              overflow_q;
  logic              blank_q;

  logic              fs_c;
  logic              we_c;
  logic              swap_c;
  logic              bank_sel_d;
  logic [FB_AW-1:0]  wr_off_c;
  logic              ptr_last_c;
  logic              addr_blank_c;
  fb_ram_addr_t      wr_addr_c;
  fb_ram_addr_t      rd_addr_c;
  logic [DATA_W-1:0] ram_rd_data;

  // Frame boundary is resolved before a coincident write: the write lands at
  // offset 0 of the bank that becomes the write bank after any swap.
  always_comb begin
    fs_c         = clk_enable & frame_start;
    we_c         = clk_enable & dma_wr_en;
    swap_c       = fs_c & (state_q == FULL);
    bank_sel_d   = bank_sel_q ^ swap_c;
    wr_off_c     = fs_c ? '0 : wr_ptr_q;
    ptr_last_c   = (wr_off_c == FB_AW'(FB_BYTES - 1));
    addr_blank_c = (32'(fb_addr) >= FB_BYTES);
    wr_addr_c    = '{bank: ~bank_sel_d, offset: wr_off_c};
    rd_addr_c    = '{bank: bank_sel_q, offset: fb_addr[FB_AW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= '0;
      bank_sel_q <= 1'b0;
      swap_q     <= 1'b0;
      short_q    <= 1'b0;
      overflow_q <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      swap_q     <= swap_c;
      bank_sel_q <= bank_sel_d;

      if (fs_c && state_q == FILLING) begin
        short_q <= 1'b1;
      end
      if (we_c && !fs_c && state_q == FULL) begin
        overflow_q <= 1'b1;
      end

      // A FULL bank keeps absorbing bytes, overwriting from offset 0.
      if (we_c) begin
        wr_ptr_q <= ptr_last_c ? '0 : wr_off_c + FB_AW'(1);
        if (ptr_last_c) begin
          state_q <= FULL;
        end else if (fs_c || state_q == EMPTY) begin
          state_q <= FILLING;
        end
      end else if (fs_c) begin
        state_q  <= EMPTY;
        wr_ptr_q <= '0;
      end

      if (fb_read_en) begin
        blank_q <= addr_blank_c;
      end
    end
  end

  pixie_fb_dpram u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (we_c),
    .wr_addr_i (wr_addr_c),
    .wr_data_i (dma_data),
    .rd_en_i   (fb_read_en),
    .rd_addr_i (rd_addr_c),
    .rd_data_o (ram_rd_data)
  );

  assign fb_data     = blank_q ? BLANK_BYTE : ram_rd_data;
  assign bank_sel    = bank_sel_q;
  assign frame_swap  = swap_q;
  assign short_frame = short_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pixie_fb_capture.sv
// Directed bench for pixie_fb_capture: frame capture, swap, flags, reads.
module tb_pixie_fb_capture;

  logic       clk;
  logic       reset;
  logic       clk_enable;
  logic       frame_start;
  logic       dma_wr_en;
  logic [7:0] dma_data;
  logic       fb_read_en;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       bank_sel;
  logic       frame_swap;
  logic       short_frame;
  logic       overflow;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  pixie_fb_capture dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .frame_start (frame_start),
    .dma_wr_en   (dma_wr_en),
    .dma_data    (dma_data),
    .fb_read_en  (fb_read_en),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .bank_sel    (bank_sel),
    .frame_swap  (frame_swap),
    .short_frame (short_frame),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    clk_enable = 1'b1;
    dma_wr_en  = 1'b1;
    dma_data   = b;
    tick();
    dma_wr_en  = 1'b0;
  endtask

  task automatic fstart();
    clk_enable  = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [9:0] addr, input logic [7:0] exp);
    fb_read_en = 1'b1;
    fb_addr    = addr;
    tick();
    fb_read_en = 1'b0;
    chk8(tag, fb_data, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk8({tag, ".fb_data"}, fb_data, 8'h00);
    chk1({tag, ".bank_sel"}, bank_sel, 1'b0);
    chk1({tag, ".frame_swap"}, frame_swap, 1'b0);
    chk1({tag, ".short_frame"}, short_frame, 1'b0);
    chk1({tag, ".overflow"}, overflow, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    clk_enable  = 1'b1;
    frame_start = 1'b0;
    dma_wr_en   = 1'b0;
    dma_data    = 8'h00;
    fb_read_en  = 1'b0;
    fb_addr     = 10'h000;
    tick();
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Empty frames right after reset: nothing swaps, nothing flagged.
    fstart();
    chk1("empty0.swap", frame_swap, 1'b0);
    fstart();
    chk1("empty1.swap", frame_swap, 1'b0);
    chk1("empty1.bank", bank_sel, 1'b0);
    chk1("empty1.short", short_frame, 1'b0);

    // Test 1: full frame 0x00..0xFF with one gated (ignored) cycle inside.
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin
        clk_enable  = 1'b0;
        dma_wr_en   = 1'b1;
        frame_start = 1'b1;
        dma_data    = 8'hEE;
        tick();
        dma_wr_en   = 1'b0;
        frame_start = 1'b0;
        clk_enable  = 1'b1;
      end
      wr(8'(i));
    end
    chk1("t1.swap_before", frame_swap, 1'b0);
    fstart();
    chk1("t1.swap", frame_swap, 1'b1);
    chk1("t1.bank", bank_sel, 1'b1);
    tick();
    chk1("t1.swap_drop", frame_swap, 1'b0);
    rd("t1.rd05", 10'h005, 8'h05);
    fb_addr = 10'h007;
    tick();
    chk8("t1.hold", fb_data, 8'h05);
    rd("t1.rd65", 10'h065, 8'h65);
    rd("t1.rd120", 10'h120, 8'h00);
    rd("t1.rdFF", 10'h0FF, 8'hFF);
    chk1("t1.short", short_frame, 1'b0);
    chk1("t1.ovf", overflow, 1'b0);

    // Test 2: short frame of 100 bytes is dropped.
    for (int i = 0; i < 100; i++) wr(8'(8'h80 | i));
    fstart();
    chk1("t2.swap", frame_swap, 1'b0);
    chk1("t2.bank", bank_sel, 1'b1);
    chk1("t2.short", short_frame, 1'b1);
    rd("t2.rd05", 10'h005, 8'h05);

    // Test 3: frame boundary with no data.
    fstart();
    chk1("t3.swap", frame_swap, 1'b0);
    chk1("t3.bank", bank_sel, 1'b1);
    chk1("t3.ovf", overflow, 1'b0);
    rd("t3.rd10", 10'h010, 8'h10);

    // Test 4: 257 bytes; last one overwrites offset 0.
    for (int i = 0; i < 256; i++) wr(8'(255 - i));
    chk1("t4.ovf_at_256", overflow, 1'b0);
    wr(8'hAA);
    chk1("t4.ovf", overflow, 1'b1);
    fstart();
    chk1("t4.swap", frame_swap, 1'b1);
    chk1("t4.bank", bank_sel, 1'b0);
    rd("t4.rd00", 10'h000, 8'hAA);
    rd("t4.rd01", 10'h001, 8'hFE);
    rd("t4.rdFF", 10'h0FF, 8'h00);

    // Test 5: frame_start and a write in the same enabled cycle.
    for (int i = 0; i < 256; i++) wr(8'(i + 1));
    clk_enable  = 1'b1;
    frame_start = 1'b1;
    dma_wr_en   = 1'b1;
    dma_data    = 8'h5A;
    tick();
    frame_start = 1'b0;
    dma_wr_en   = 1'b0;
    chk1("t5.swap", frame_swap, 1'b1);
    chk1("t5.bank", bank_sel, 1'b1);
    rd("t5.rd00", 10'h000, 8'h01);
    rd("t5.rdFF", 10'h0FF, 8'h00);
    for (int a = 1; a < 256; a++) wr(8'(a ^ 8'hC3));
    chk1("t5.swap_idle", frame_swap, 1'b0);
    fstart();
    chk1("t5.swap2", frame_swap, 1'b1);
    chk1("t5.bank2", bank_sel, 1'b0);
    rd("t5.rd00b", 10'h000, 8'h5A);
    rd("t5.rd01b", 10'h001, 8'hC2);
    rd("t5.rd80b", 10'h080, 8'h43);
    chk1("t5.ovf_sticky", overflow, 1'b1);
    chk1("t5.short_sticky", short_frame, 1'b1);

    // Test 6: reset mid-frame, then a clean frame.
    for (int i = 0; i < 50; i++) wr(8'hEE);
    reset = 1'b1;
    tick();
    chk_reset_outputs("t6.reset");
    reset = 1'b0;
    for (int i = 0; i < 256; i++) wr(8'(i ^ 8'h55));
    fstart();
    chk1("t6.swap", frame_swap, 1'b1);
    chk1("t6.bank", bank_sel, 1'b1);
    chk1("t6.short", short_frame, 1'b0);
    chk1("t6.ovf", overflow, 1'b0);
    rd("t6.rd00", 10'h000, 8'h55);
    rd("t6.rd31", 10'h031, 8'h64);
    rd("t6.rd200", 10'h200, 8'h00);
    rd("t6.rd3FF", 10'h3FF, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
